// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump flush and multi-cycle EX holds.
// Define PIPE_HAZARD_FWD_EN to enable operand forwarding selects.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W    = 5,
    parameter int JMP_FLUSH_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_re,
    input  logic                  id_rs2_re,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_rd_we,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_rd_we,
    input  logic                  ex_jump_req,
    input  logic                  ex_mc_start,
    input  logic                  ex_mc_done,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  ifid_flush,
    output logic                  idex_hold,
    output logic                  idex_flush,
    output logic                  exmem_bubble,
`ifdef PIPE_HAZARD_FWD_EN
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel,
`endif
    output logic [31:0]           stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MCWAIT = 2'd1,
        JFLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(JMP_FLUSH_CYC - 1);

    state_t     state;
    state_t     state_n;
    logic [2:0] fcnt;
    logic [2:0] fcnt_n;

    logic rs1_ok;
    logic rs2_ok;
    logic ex_hit1;
    logic ex_hit2;
    logic mem_hit1;
    logic mem_hit2;
    logic load_use;
    logic stall_req;

    // x0 reads are never hazards, so the address test gates every match
    assign rs1_ok   = id_rs1_re && (id_rs1 != '0);
    assign rs2_ok   = id_rs2_re && (id_rs2 != '0);
    assign ex_hit1  = rs1_ok && ex_rd_we && (ex_rd == id_rs1);
    assign ex_hit2  = rs2_ok && ex_rd_we && (ex_rd == id_rs2);
    assign mem_hit1 = rs1_ok && mem_rd_we && (mem_rd == id_rs1);
    assign mem_hit2 = rs2_ok && mem_rd_we && (mem_rd == id_rs2);
    assign load_use = ex_is_load && (ex_hit1 || ex_hit2);

`ifdef PIPE_HAZARD_FWD_EN
    assign stall_req = load_use;

    always_comb begin
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        if (!rst) begin
            if (ex_hit1 && !ex_is_load) begin
                fwd_rs1_sel = 2'b01;
            end else if (mem_hit1) begin
                fwd_rs1_sel = 2'b10;
            end
            if (ex_hit2 && !ex_is_load) begin
                fwd_rs2_sel = 2'b01;
            end else if (mem_hit2) begin
                fwd_rs2_sel = 2'b10;
            end
        end
    end
`else
    // Without forwarding every in-flight producer must drain first
    assign stall_req = load_use || ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
`endif

    always_comb begin
        state_n      = state;
        fcnt_n       = fcnt;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_n    = RUN;
            fcnt_n     = 3'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_jump_req) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        fcnt_n     = FLUSH_LOAD;
                        state_n    = (JMP_FLUSH_CYC > 1) ? JFLUSH : RUN;
                    end else if (ex_mc_start) begin
                        state_n = MCWAIT;
                    end else if (stall_req) begin
                        pc_hold    = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                MCWAIT: begin
                    if (ex_mc_done) begin
                        state_n = RUN;
                    end else begin
                        pc_hold      = 1'b1;
                        ifid_hold    = 1'b1;
                        idex_hold    = 1'b1;
                        exmem_bubble = 1'b1;
                    end
                end
                JFLUSH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    // leave once the decrement reaches zero
                    if (fcnt <= 3'd1) begin
                        fcnt_n  = 3'd0;
                        state_n = RUN;
                    end else begin
                        fcnt_n = fcnt - 3'd1;
                    end
                end
                default: begin
                    state_n = RUN;
                    fcnt_n  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= 3'd0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (pc_hold) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors, negedge monitor.
// Covers both builds of PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_RST  = 6'b001010;
    localparam logic [5:0] C_FL   = 6'b001010;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_MC   = 6'b110101;
`ifdef PIPE_HAZARD_FWD_EN
    localparam logic [5:0] C_FWD  = C_NONE;
`else
    localparam logic [5:0] C_FWD  = C_LU;
`endif

    typedef struct {
        string       name;
        logic [5:0]  ctl;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic        id_rs1_re, id_rs2_re, ex_rd_we, ex_is_load, mem_rd_we;
    logic        ex_jump_req, ex_mc_start, ex_mc_done;
    logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
    logic        exmem_bubble;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0] stall_cnt;

    exp_t        q[$];
    logic [31:0] ecnt;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .JMP_FLUSH_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_rd_we(mem_rd_we),
        .ex_jump_req(ex_jump_req),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_hold(idex_hold), .idex_flush(idex_flush),
        .exmem_bubble(exmem_bubble),
`ifdef PIPE_HAZARD_FWD_EN
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
`endif
        .stall_cnt(stall_cnt)
    );

`ifndef PIPE_HAZARD_FWD_EN
    assign fwd_rs1_sel = 2'b00;
    assign fwd_rs2_sel = 2'b00;
`endif

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t       e;
            logic [5:0] act;
            logic       bad;
            e   = q.pop_front();
            act = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
                   exmem_bubble};
            bad = (act !== e.ctl) || (stall_cnt !== e.cnt);
`ifdef PIPE_HAZARD_FWD_EN
            bad = bad || (fwd_rs1_sel !== e.f1) || (fwd_rs2_sel !== e.f2);
`endif
            n_chk++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b cnt=%h f1=%b f2=%b, want ctl=%b cnt=%h f1=%b f2=%b",
                         e.name, act, stall_cnt, fwd_rs1_sel, fwd_rs2_sel,
                         e.ctl, e.cnt, e.f1, e.f2);
            end
        end
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_re = 0; id_rs2_re = 0;
        ex_rd = 0; ex_rd_we = 0; ex_is_load = 0;
        mem_rd = 0; mem_rd_we = 0;
        ex_jump_req = 0; ex_mc_start = 0; ex_mc_done = 0;
    endtask

    task automatic cyc(input string nm, input logic [5:0] c,
                       input logic [1:0] f1 = 2'b00,
                       input logic [1:0] f2 = 2'b00);
        exp_t e;
        e.name = nm; e.ctl = c; e.f1 = f1; e.f2 = f2; e.cnt = ecnt;
        q.push_back(e);
        if (rst) ecnt = 32'd0;
        else if (c[5]) ecnt = ecnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst  = 1'b1;
        ecnt = 32'd0;
        @(posedge clk);
        #1;
        cyc("rst0", C_RST);
        cyc("rst1", C_RST);
        rst = 1'b0;
        cyc("idle", C_NONE);

        ex_is_load = 1; ex_rd = 5; ex_rd_we = 1; id_rs2 = 5; id_rs2_re = 1;
        cyc("load_use", C_LU);
        idle();
        cyc("after_lu", C_NONE);

        ex_is_load = 1; ex_rd = 0; ex_rd_we = 1; id_rs1 = 0; id_rs1_re = 1;
        cyc("x0_load", C_NONE);
        ex_rd = 5; id_rs1 = 5; id_rs1_re = 0;
        cyc("re_off", C_NONE);
        idle();

        mem_rd = 9; mem_rd_we = 1; id_rs1 = 9; id_rs1_re = 1;
        cyc("mem_hit", C_FWD, 2'b10, 2'b00);
        idle();
        ex_rd = 3; ex_rd_we = 1; id_rs2 = 3; id_rs2_re = 1;
        cyc("ex_alu_hit", C_FWD, 2'b00, 2'b01);
        idle();

        ex_rd = 7; ex_rd_we = 1; mem_rd = 7; mem_rd_we = 1;
        id_rs1 = 7; id_rs1_re = 1;
        cyc("fwd_ex_pri", C_FWD, 2'b01, 2'b00);
        ex_rd_we = 0;
        cyc("fwd_mem", C_FWD, 2'b10, 2'b00);
        id_rs1 = 0;
        cyc("fwd_x0", C_NONE, 2'b00, 2'b00);
        idle();

        ex_jump_req = 1;
        ex_is_load = 1; ex_rd = 5; ex_rd_we = 1; id_rs2 = 5; id_rs2_re = 1;
        cyc("jump_lu", C_FL);
        ex_jump_req = 0;
        cyc("jflush_2", C_FL);
        idle();
        cyc("jump_done", C_NONE);

        ex_mc_start = 1;
        cyc("mc_start", C_NONE);
        ex_mc_start = 0;
        cyc("mc_w1", C_MC);
        ex_jump_req = 1;
        cyc("mc_w2_jmp", C_MC);
        ex_jump_req = 0;
        cyc("mc_w3", C_MC);
        cyc("mc_w4", C_MC);
        ex_mc_done = 1;
        cyc("mc_done", C_NONE);
        idle();
        cyc("mc_after", C_NONE);

        ex_mc_start = 1;
        cyc("mc2_start", C_NONE);
        ex_mc_start = 0;
        cyc("mc2_w1", C_MC);
        rst = 1;
        cyc("mc2_rst", C_RST);
        rst = 0;
        cyc("mc2_post", C_NONE);
        cyc("mc2_post2", C_NONE);

        ex_jump_req = 1;
        cyc("j2_start", C_FL);
        ex_jump_req = 0;
        rst = 1;
        cyc("j2_rst", C_RST);
        rst = 0;
        cyc("j2_post", C_NONE);

        dut.stall_cnt = 32'hFFFF_FFFF;
        ecnt = 32'hFFFF_FFFF;
        ex_is_load = 1; ex_rd = 12; ex_rd_we = 1; id_rs1 = 12; id_rs1_re = 1;
        cyc("wrap_stall", C_LU);
        idle();
        cyc("wrap_zero", C_NONE);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
